// File: rtl/keypad_pkg.sv
// Shared types, defaults and helpers for the keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    StScan,
    StDebounce,
    StPressed,
    StRelease
  } state_t;

  localparam int unsigned DebounceMsDefault = 20;
  localparam int unsigned RowHoldDefault    = 4;

  // Active-low one-hot row drive for a row index.
  function automatic logic [3:0] row_drive(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  // Returns {single_low, col_idx}; single_low is set only when exactly one column reads low.
  function automatic logic [2:0] decode_col(input logic [3:0] cols);
    logic [2:0] res;
    res = 3'b000;
    unique case (cols)
      4'b1110: res = 3'b100;
      4'b1101: res = 3'b101;
      4'b1011: res = 3'b110;
      4'b0111: res = 3'b111;
      default: res = 3'b000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/col_sync.sv
// Two-flop synchronizer for the asynchronous, active-low keypad columns.
module col_sync (
  input  logic       clk_1khz,
  input  logic       rst_n,
  input  logic [3:0] col,
  output logic [3:0] scol
);

  logic [3:0] meta_q;
  logic [3:0] sync_q;

  // Reset to all ones so an idle (pulled-up) keypad is seen during and after reset.
  always_ff @(posedge clk_1khz or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 4'b1111;
      sync_q <= 4'b1111;
    end else begin
      meta_q <= col;
      sync_q <= meta_q;
    end
  end

  assign scol = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with press and release debouncing.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_MS = DebounceMsDefault,
  parameter int unsigned ROW_HOLD    = RowHoldDefault
) (
  input  logic       clk_1khz,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam logic [7:0] DebLast  = 8'(DEBOUNCE_MS - 1);
  localparam logic [3:0] HoldLast = 4'(ROW_HOLD - 1);

  logic [3:0] scol;
  state_t     state_q, state_d;
  logic [3:0] row_q, row_d;
  logic [1:0] row_idx_q, row_idx_d;
  logic [1:0] col_idx_q, col_idx_d;
  logic [3:0] hold_q, hold_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] key_code_q, key_code_d;
  logic       key_valid_q, key_valid_d;
  logic       key_down_q, key_down_d;
  logic [2:0] dec;
  logic       col_high;
  logic [1:0] next_idx;

  col_sync u_col_sync (
    .clk_1khz (clk_1khz),
    .rst_n    (rst_n),
    .col      (col),
    .scol     (scol)
  );

  assign dec      = decode_col(scol);
  assign col_high = scol[col_idx_q];
  assign next_idx = row_idx_q + 2'd1;

  // State and output registers.
  always_ff @(posedge clk_1khz or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StScan;
      row_q       <= 4'b1111;
      row_idx_q   <= 2'd0;
      col_idx_q   <= 2'd0;
      hold_q      <= 4'd0;
      cnt_q       <= 8'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      row_idx_q   <= row_idx_d;
      col_idx_q   <= col_idx_d;
      hold_q      <= hold_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_down_q  <= key_down_d;
    end
  end

  // Next-state logic: scan rows, debounce press, hold, debounce release.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    row_idx_d   = row_idx_q;
    col_idx_d   = col_idx_q;
    hold_d      = hold_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_down_d  = key_down_q;

    if (!en) begin
      state_d    = StScan;
      row_d      = 4'b1111;
      row_idx_d  = 2'd0;
      hold_d     = 4'd0;
      cnt_d      = 8'd0;
      key_down_d = 1'b0;
    end else begin
      unique case (state_q)
        StScan: begin
          if (row_q == 4'b1111) begin
            // Coming out of reset or disable: start driving the current row.
            row_d  = row_drive(row_idx_q);
            hold_d = 4'd0;
          end else if (hold_q >= HoldLast) begin
            if (dec[2]) begin
              col_idx_d = dec[1:0];
              cnt_d     = 8'd0;
              state_d   = StDebounce;
            end else begin
              row_idx_d = next_idx;
              row_d     = row_drive(next_idx);
              hold_d    = 4'd0;
            end
          end else if (hold_q != 4'hf) begin
            hold_d = hold_q + 4'd1;
          end
        end
        StDebounce: begin
          if (col_high) begin
            state_d   = StScan;
            row_idx_d = next_idx;
            row_d     = row_drive(next_idx);
            hold_d    = 4'd0;
            cnt_d     = 8'd0;
          end else if (cnt_q >= DebLast) begin
            state_d     = StPressed;
            key_code_d  = {row_idx_q, col_idx_q};
            key_valid_d = 1'b1;
            key_down_d  = 1'b1;
            cnt_d       = 8'd0;
          end else if (cnt_q != 8'hff) begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        StPressed: begin
          if (col_high) begin
            state_d = StRelease;
            cnt_d   = 8'd0;
          end
        end
        StRelease: begin
          if (!col_high) begin
            state_d = StPressed;
            cnt_d   = 8'd0;
          end else if (cnt_q >= DebLast) begin
            state_d    = StScan;
            key_down_d = 1'b0;
            row_idx_d  = next_idx;
            row_d      = row_drive(next_idx);
            hold_d     = 4'd0;
            cnt_d      = 8'd0;
          end else if (cnt_q != 8'hff) begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: state_d = StScan;
      endcase
    end
  end

  assign row       = row_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_down  = key_down_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner using a physical 4x4 key-matrix model.
module tb_keypad_scanner;

  logic        clk_1khz = 1'b0;
  logic        rst_n    = 1'b0;
  logic        en       = 1'b0;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_down;
  logic [15:0] keys     = 16'h0;

  int checks   = 0;
  int failures = 0;
  logic [3:0] exp_codes[$];
  logic [3:0] exp_rows[$];

  keypad_scanner #(
    .DEBOUNCE_MS (20),
    .ROW_HOLD    (4)
  ) dut (
    .clk_1khz  (clk_1khz),
    .rst_n     (rst_n),
    .en        (en),
    .col       (col),
    .row       (row),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_down  (key_down)
  );

  always #5 clk_1khz = ~clk_1khz;

  // A pressed key shorts its column to its row: the column reads low only while that row is driven.
  always_comb begin
    col = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && (row[r] === 1'b0)) col[c] = 1'b0;
      end
    end
  end

  task automatic step();
    @(negedge clk_1khz);
  endtask

  // Wait for the first cycle of a fresh drive of the target row.
  task automatic wait_row(input logic [3:0] target);
    int n;
    n = 0;
    while (row === target && n < 40) begin step(); n++; end
    while (row !== target && n < 80) begin step(); n++; end
    checks++;
    if (row !== target) begin
      failures++;
      $display("FAIL wait_row: row=%b required=%b", row, target);
    end
  endtask

  task automatic press_and_accept(input int r, input int c, output int lat);
    logic [3:0] exp;
    wait_row(~(4'b0001 << r));
    keys[r*4+c] = 1'b1;
    exp_codes.push_back(4'(r*4 + c));
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (key_valid === 1'b1) begin lat = i; break; end
    end
    exp = exp_codes.pop_front();
    checks++;
    if (lat < 0) begin
      failures++;
      $display("FAIL key_valid_timeout: no pulse within 60 cycles, required code=%0d", exp);
    end else begin
      checks++;
      if (key_code !== exp) begin
        failures++;
        $display("FAIL key_code: got=%0d required=%0d", key_code, exp);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; keys = 16'h0;
    repeat (3) step();
    checks++;
    if (row !== 4'b1111 || key_code !== 4'd0 || key_valid !== 1'b0 || key_down !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: row=%b code=%0d valid=%b down=%b required 1111/0/0/0",
               row, key_code, key_valid, key_down);
    end
    for (int i = 0; i < 16; i++) exp_rows.push_back(~(4'b0001 << (i / 4)));
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      logic [3:0] exp;
      step();
      exp = exp_rows.pop_front();
      checks++;
      if (row !== exp) begin
        failures++;
        $display("FAIL scan_row[%0d]: got=%b required=%b", i, row, exp);
      end
    end
  endtask

  task automatic test_clean_press();
    int lat, extra, rel;
    extra = 0; rel = -1;
    press_and_accept(2, 1, lat);
    checks++;
    if (lat !== 24) begin
      failures++;
      $display("FAIL press_latency: got=%0d required=24", lat);
    end
    step();
    checks++;
    if (key_valid !== 1'b0 || key_down !== 1'b1) begin
      failures++;
      $display("FAIL pulse_width: valid=%b down=%b required valid=0 down=1", key_valid, key_down);
    end
    repeat (15) begin step(); if (key_valid === 1'b1) extra++; end
    checks++;
    if (row !== 4'b1011) begin
      failures++;
      $display("FAIL row_frozen: got=%b required=1011", row);
    end
    keys = 16'h0;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (key_valid === 1'b1) extra++;
      if (key_down === 1'b0) begin rel = i; break; end
    end
    checks++;
    if (rel !== 23) begin
      failures++;
      $display("FAIL release_latency: got=%0d required=23", rel);
    end
    checks++;
    if (extra !== 0) begin
      failures++;
      $display("FAIL extra_valid_clean: got=%0d required=0", extra);
    end
    checks++;
    if (row !== 4'b0111) begin
      failures++;
      $display("FAIL resume_row_after_release: got=%b required=0111", row);
    end
  endtask

  task automatic test_press_bounce();
    int extra;
    logic [3:0] first_new;
    extra = 0; first_new = 4'b1011;
    wait_row(4'b1011);
    keys[2*4+1] = 1'b1;
    repeat (5) begin step(); if (key_valid === 1'b1) extra++; end
    keys = 16'h0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (key_valid === 1'b1 || key_down === 1'b1) extra++;
      if (first_new === 4'b1011 && row !== 4'b1011) first_new = row;
    end
    checks++;
    if (extra !== 0) begin
      failures++;
      $display("FAIL press_bounce_valid: got=%0d required=0", extra);
    end
    checks++;
    if (first_new !== 4'b0111) begin
      failures++;
      $display("FAIL press_bounce_next_row: got=%b required=0111", first_new);
    end
  endtask

  task automatic test_release_bounce();
    int lat, extra, bad, rel;
    extra = 0; bad = 0; rel = -1;
    press_and_accept(0, 3, lat);
    repeat (5) step();
    keys = 16'h0;
    repeat (5) begin
      step();
      if (key_valid === 1'b1) extra++;
      if (key_down !== 1'b1) bad++;
    end
    keys[0*4+3] = 1'b1;
    repeat (40) begin
      step();
      if (key_valid === 1'b1) extra++;
      if (key_down !== 1'b1) bad++;
    end
    checks++;
    if (extra !== 0) begin
      failures++;
      $display("FAIL release_bounce_valid: got=%0d required=0", extra);
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL release_bounce_down: low_cycles=%0d required=0", bad);
    end
    keys = 16'h0;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (key_down === 1'b0) begin rel = i; break; end
    end
    checks++;
    if (rel < 0) begin
      failures++;
      $display("FAIL release_timeout: key_down=%b required=0", key_down);
    end
  endtask

  task automatic test_two_keys();
    int extra;
    extra = 0;
    wait_row(4'b1101);
    keys[1*4+1] = 1'b1;
    keys[1*4+2] = 1'b1;
    repeat (4) begin step(); if (key_valid === 1'b1) extra++; end
    checks++;
    if (row !== 4'b1011) begin
      failures++;
      $display("FAIL two_keys_advance: got=%b required=1011", row);
    end
    keys = 16'h0;
    checks++;
    if (extra !== 0 || key_down !== 1'b0) begin
      failures++;
      $display("FAIL two_keys_valid: pulses=%0d down=%b required 0/0", extra, key_down);
    end
  endtask

  task automatic test_enable_drop();
    int lat;
    press_and_accept(3, 2, lat);
    step();
    en = 1'b0;
    step();
    checks++;
    if (row !== 4'b1111 || key_down !== 1'b0 || key_valid !== 1'b0 || key_code !== 4'd14) begin
      failures++;
      $display("FAIL en_drop: row=%b down=%b valid=%b code=%0d required 1111/0/0/14",
               row, key_down, key_valid, key_code);
    end
    repeat (3) step();
    keys = 16'h0;
    en = 1'b1;
    step();
    checks++;
    if (row !== 4'b1110 || key_code !== 4'd14) begin
      failures++;
      $display("FAIL en_resume: row=%b code=%0d required 1110/14", row, key_code);
    end
  endtask

  task automatic test_reset_in_debounce();
    int extra;
    extra = 0;
    wait_row(4'b1110);
    keys[0] = 1'b1;
    repeat (10) begin step(); if (key_valid === 1'b1) extra++; end
    rst_n = 1'b0;
    #1;
    checks++;
    if (row !== 4'b1111 || key_code !== 4'd0 || key_down !== 1'b0 || key_valid !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: row=%b code=%0d down=%b valid=%b required 1111/0/0/0",
               row, key_code, key_down, key_valid);
    end
    keys = 16'h0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (40) begin step(); if (key_valid === 1'b1) extra++; end
    checks++;
    if (extra !== 0) begin
      failures++;
      $display("FAIL reset_abort_valid: got=%0d required=0", extra);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_press_bounce();
    test_release_bounce();
    test_two_keys();
    test_enable_drop();
    test_reset_in_debounce();
    checks++;
    if (exp_codes.size() !== 0) begin
      failures++;
      $display("FAIL scoreboard_drain: left=%0d required=0", exp_codes.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
